vga_timing_checker: RTL and testbench
=====================================

VGA_TIMING_CHECKER -- requirements
Module: vga_timing_checker

Interface
REQ-001 Parameters (name, default, meaning), the SHALL-fixed default frame being 1024x768 at 1344x806 total:
- H_TOTAL, 1344, clocks per line.
- V_TOTAL, 806, lines per frame.
- H_ACTIVE, 1024, visible pixels per line.
- V_ACTIVE, 768, visible lines.
- H_SYNC_START, 1048, hsync first pixel.
- H_SYNC_W, 112, hsync width in clocks.
- V_SYNC_START, 768, vsync first line.
- V_SYNC_W, 6, vsync width in lines.
- LOCK_FRAMES, 2, consecutive clean frames required to lock.

REQ-002 Ports (name, direction, width, meaning), all outputs registered; reset rst is asynchronous, active-high; clock clk:
- clk, in, 1, pixel clock.
- rst, in, 1, asynchronous active-high reset.
- in (vga_if.in), in, bus; only hsync, vsync, hblnk and vblnk are used, hcount/vcount are ignored.
- x_pos, out, 11, recovered pixel column.
- y_pos, out, 11, recovered line.
- de, out, 1, active-video enable.
- locked, out, 1, stream timing verified.
- err, out, 1, one-cycle error pulse.
- err_cnt, out, 8, saturating error count.

Function
REQ-003 Inputs SHALL be sampled each clk into a one-deep history (s_*, p_*); every output SHALL reflect input sample t at cycle t+1 (latency 1).
REQ-004 Line start SHALL be the sample where p_hblnk=1 and s_hblnk=0; internal x SHALL be 0 there and increment by 1 otherwise, saturating at 2047.
REQ-005 Frame start SHALL be a line start where p_vblnk=1 and s_vblnk=0; internal y SHALL be 0 there, increment at every other line start, and saturate at 2047.
REQ-006 The line-length check SHALL fail at a line start (after the first line start seen since reset) when the previous x != H_TOTAL-1, and once when x reaches 2047.
REQ-007 The hsync check SHALL fail if a hsync rising edge occurs at x != H_SYNC_START or a falling edge at x != H_SYNC_START+H_SYNC_W.
REQ-008 The vsync check SHALL fail if any vsync edge occurs off a line start, a rising edge occurs at y != V_SYNC_START, or a falling edge occurs at y != V_SYNC_START+V_SYNC_W.
REQ-009 The frame check SHALL fail at a frame start (after the first frame start since reset) when the previous y != V_TOTAL-1.
REQ-010 FSM states SHALL be UNLOCKED, ALIGN and LOCKED:
- UNLOCKED -> ALIGN on a frame start; good-frame counter cleared.
- ALIGN: each subsequent frame start with no failure during the completed frame increments the counter; any failure clears it; reaching LOCK_FRAMES -> LOCKED.
- LOCKED: any failure -> UNLOCKED.
REQ-011 locked SHALL equal (state==LOCKED); de SHALL equal locked & !s_hblnk & !s_vblnk, registered.
REQ-012 err SHALL pulse one cycle for each sample with at least one failure (any state); simultaneous failures SHALL yield one pulse.
REQ-013 Each err pulse SHALL increment err_cnt by exactly 1, saturating at 255.
REQ-014 Input checks only; no correction or regeneration of the sync signals.

Reset
REQ-015 On rst, outputs SHALL be x_pos=0, y_pos=0, de=0, locked=0, err=0, err_cnt=0; state UNLOCKED; history, x, y, counter and first-seen flags cleared.
REQ-016 Reset mid-frame SHALL discard all alignment; relock SHALL require a frame start plus LOCK_FRAMES clean frames.
REQ-017 The first line start and frame start after reset SHALL NOT raise length failures.

Configuration
REQ-018 Macro VGA_TIMING_CHECKER_ERRCNT_EN:
- Defined: err_cnt behaves per REQ-013.
- Undefined: err_cnt SHALL be constant 0 with no counter logic; err, locked and all checks are unchanged.

Verification
REQ-019 Clean default-timing stream from reset -> locked rises 1 cycle after the third frame-start sample; err never pulses; de high for exactly 1024x768 cycles per frame; x_pos=0 and y_pos=0 one cycle after the generator's pixel (0,0).
REQ-020 While locked, one line shortened to 1343 clocks -> single err pulse at that line start, err_cnt=1, locked=0 next cycle, relock after 3 further frame starts.
REQ-021 hsync moved to start at 1049 on one line -> err pulses on the rising and falling edges of that hsync, err_cnt=2, locked=0.
REQ-022 rst asserted at line 400, pixel 500, then released -> all outputs 0 immediately; locked returns only after 3 frame starts with no false err.
REQ-023 300 corrupted lines -> err_cnt saturates at 255, with no wrap to 0.
REQ-024 Macro undefined, scenario REQ-020 -> err pulse and locked drop unchanged, err_cnt stays 0.

Source files
------------

// File: rtl/vga_timing_checker_if.sv
// rtl/vga_timing_checker_if.sv - VGA timing bundle shared by stream sources and the checker
interface vga_if;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [10:0] hcount;
  logic [10:0] vcount;

  modport in  (input  hsync, vsync, hblnk, vblnk, hcount, vcount);
  modport out (output hsync, vsync, hblnk, vblnk, hcount, vcount);
endinterface

// File: rtl/vga_timing_checker.sv
// rtl/vga_timing_checker.sv - VGA sync timing checker with lock FSM; VGA_TIMING_CHECKER_ERRCNT_EN enables err_cnt
module vga_timing_checker #(
  parameter int H_TOTAL      = 1344,
  parameter int V_TOTAL      = 806,
  parameter int H_ACTIVE     = 1024,
  parameter int V_ACTIVE     = 768,
  parameter int H_SYNC_START = 1048,
  parameter int H_SYNC_W     = 112,
  parameter int V_SYNC_START = 768,
  parameter int V_SYNC_W     = 6,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  vga_if.in           in,
  output logic [10:0] x_pos,
  output logic [10:0] y_pos,
  output logic        de,
  output logic        locked,
  output logic        err,
  output logic [7:0]  err_cnt
);
  localparam logic [1:0] UNLOCKED = 2'd0;
  localparam logic [1:0] ALIGN    = 2'd1;
  localparam logic [1:0] LOCKED   = 2'd2;

  localparam logic [10:0] POS_MAX = 11'd2047;
  localparam logic [10:0] X_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] Y_LAST  = 11'(V_TOTAL - 1);
  localparam logic [10:0] HS_RISE = 11'(H_SYNC_START);
  localparam logic [10:0] HS_FALL = 11'(H_SYNC_START + H_SYNC_W);
  localparam logic [10:0] VS_RISE = 11'(V_SYNC_START);
  localparam logic [10:0] VS_FALL = 11'(V_SYNC_START + V_SYNC_W);
  localparam logic [7:0]  LOCK_N  = 8'(LOCK_FRAMES);

  logic        s_hsync, s_vsync, s_hblnk, s_vblnk;
  logic        p_hsync, p_vsync, p_hblnk, p_vblnk;
  logic        line_seen, frame_seen, frame_bad;
  logic        line_start, frame_start;
  logic        fail_len, fail_hs, fail_vs, fail_fr, fail;
  logic [10:0] x_next, y_next;
  logic [1:0]  state, state_next;
  logic [7:0]  good_cnt, good_cnt_next;
  logic        unused_inputs;

  // Counters and active sizes come from the blanking flags, not from the source's own counts
  assign unused_inputs = ^{in.hcount, in.vcount, 11'(H_ACTIVE), 11'(V_ACTIVE)};

  assign s_hsync = in.hsync;
  assign s_vsync = in.vsync;
  assign s_hblnk = in.hblnk;
  assign s_vblnk = in.vblnk;

  assign line_start  = p_hblnk & ~s_hblnk;
  assign frame_start = line_start & p_vblnk & ~s_vblnk;

  assign x_next = line_start ? 11'd0 : (x_pos == POS_MAX) ? POS_MAX : x_pos + 11'd1;
  assign y_next = frame_start ? 11'd0
                : (line_start && (y_pos != POS_MAX)) ? y_pos + 11'd1 : y_pos;

  // Edge checks use the position the current sample is assigned, i.e. x_next/y_next
  assign fail_len = (line_start & line_seen & (x_pos != X_LAST))
                  | (~line_start & (x_pos == POS_MAX - 11'd1));
  assign fail_hs  = line_seen & (((~p_hsync & s_hsync) & (x_next != HS_RISE))
                               | ((p_hsync & ~s_hsync) & (x_next != HS_FALL)));
  assign fail_vs  = frame_seen & (p_vsync ^ s_vsync)
                  & (~line_start | (s_vsync ? (y_next != VS_RISE) : (y_next != VS_FALL)));
  assign fail_fr  = frame_start & frame_seen & (y_pos != Y_LAST);
  assign fail     = fail_len | fail_hs | fail_vs | fail_fr;

  always_comb begin
    state_next    = state;
    good_cnt_next = good_cnt;
    case (state)
      UNLOCKED: begin
        if (frame_start) begin
          state_next    = ALIGN;
          good_cnt_next = 8'd0;
        end
      end
      ALIGN: begin
        if (fail) begin
          good_cnt_next = 8'd0;
        end else if (frame_start && !frame_bad) begin
          if (good_cnt + 8'd1 >= LOCK_N) begin
            state_next    = LOCKED;
            good_cnt_next = 8'd0;
          end else begin
            good_cnt_next = good_cnt + 8'd1;
          end
        end
      end
      LOCKED: begin
        if (fail) state_next = UNLOCKED;
      end
      default: state_next = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_hsync    <= 1'b0;
      p_vsync    <= 1'b0;
      p_hblnk    <= 1'b0;
      p_vblnk    <= 1'b0;
      x_pos      <= 11'd0;
      y_pos      <= 11'd0;
      line_seen  <= 1'b0;
      frame_seen <= 1'b0;
      frame_bad  <= 1'b0;
      state      <= UNLOCKED;
      good_cnt   <= 8'd0;
      locked     <= 1'b0;
      de         <= 1'b0;
      err        <= 1'b0;
    end else begin
      p_hsync    <= s_hsync;
      p_vsync    <= s_vsync;
      p_hblnk    <= s_hblnk;
      p_vblnk    <= s_vblnk;
      x_pos      <= x_next;
      y_pos      <= y_next;
      line_seen  <= line_seen | line_start;
      frame_seen <= frame_seen | frame_start;
      // A frame-start sample closes the previous frame, so its failure is not carried forward
      frame_bad  <= frame_start ? 1'b0 : (frame_bad | fail);
      state      <= state_next;
      good_cnt   <= good_cnt_next;
      locked     <= (state_next == LOCKED);
      de         <= (state_next == LOCKED) & ~s_hblnk & ~s_vblnk;
      err        <= fail;
    end
  end

`ifdef VGA_TIMING_CHECKER_ERRCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= 8'd0;
    end else if (fail && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`else
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_vga_timing_checker.sv
// tb/tb_vga_timing_checker.sv - randomized model-checked bench for vga_timing_checker
module tb_vga_timing_checker;
  localparam int HT = 24, HA = 16, HSS = 18, HSW = 3;
  localparam int VT = 10, VA = 6, VSS = 7, VSW = 2, LOCK = 2;
`ifdef VGA_TIMING_CHECKER_ERRCNT_EN
  localparam int CNT_EN = 1;
`else
  localparam int CNT_EN = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  vga_if vif();
  logic [10:0] x_pos, y_pos;
  logic de, locked, err;
  logic [7:0] err_cnt;

  vga_timing_checker #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA),
    .H_SYNC_START(HSS), .H_SYNC_W(HSW), .V_SYNC_START(VSS), .V_SYNC_W(VSW),
    .LOCK_FRAMES(LOCK)
  ) dut (
    .clk(clk), .rst(rst), .in(vif),
    .x_pos(x_pos), .y_pos(y_pos), .de(de), .locked(locked), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_bad = 0;
  int cyc = 0;
  bit org = 0;
  bit cap_new, cap_hs, cap_vs, cap_hb, cap_vb, cap_org;
  int fs_cyc[$];
  int err_total = 0, de_total = 0, lock_rise_cyc = -1;
  bit prev_locked = 0;

  int m_idx, m_ls_idx, m_x, m_lines, m_mode, m_good, m_cnt;
  bit m_line_seen, m_frame_seen, m_bad, m_err, m_de;
  bit m_phs, m_pvs, m_phb, m_pvb;

  function automatic void chk(input string name, input int act, input int exp);
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic m_reset();
    m_idx = -1; m_ls_idx = -1; m_x = 0; m_lines = 0;
    m_mode = 0; m_good = 0; m_cnt = 0;
    m_line_seen = 0; m_frame_seen = 0; m_bad = 0; m_err = 0; m_de = 0;
    m_phs = 0; m_pvs = 0; m_phb = 0; m_pvb = 0;
  endtask

  // x = samples since last line start (or since reset), y = line starts since last frame start
  task automatic m_step(input bit hs, input bit vs, input bit hb, input bit vb);
    int x_old, y_old;
    bit ls, fs, f;
    x_old = m_x;
    y_old = m_lines;
    ls = m_phb && !hb;
    fs = ls && m_pvb && !vb;
    m_idx++;
    if (ls) m_ls_idx = m_idx;
    m_x = (m_idx - m_ls_idx > 2047) ? 2047 : m_idx - m_ls_idx;
    if (fs) m_lines = 0;
    else if (ls && m_lines < 2047) m_lines++;
    f = 0;
    if (ls && m_line_seen && x_old != HT - 1) f = 1;
    if (m_x == 2047 && x_old != 2047) f = 1;
    if (m_line_seen && hs != m_phs && m_x != (hs ? HSS : HSS + HSW)) f = 1;
    if (m_frame_seen && vs != m_pvs && (!ls || m_lines != (vs ? VSS : VSS + VSW))) f = 1;
    if (fs && m_frame_seen && y_old != VT - 1) f = 1;
    if (ls) m_line_seen = 1;
    if (fs) m_frame_seen = 1;
    if (m_mode == 2) begin
      if (f) m_mode = 0;
    end else if (m_mode == 0) begin
      if (fs) begin m_mode = 1; m_good = 0; end
    end else begin
      if (f) m_good = 0;
      else if (fs && !m_bad) begin
        m_good++;
        if (m_good == LOCK) m_mode = 2;
      end
    end
    m_bad = fs ? 1'b0 : (m_bad || f);
    m_err = f;
    if (f && m_cnt < 255) m_cnt++;
    m_de = (m_mode == 2) && !hb && !vb;
    m_phs = hs; m_pvs = vs; m_phb = hb; m_pvb = vb;
  endtask

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    cap_new <= !rst;
    cap_hs  <= vif.hsync;
    cap_vs  <= vif.vsync;
    cap_hb  <= vif.hblnk;
    cap_vb  <= vif.vblnk;
    cap_org <= org;
  end

  initial begin
    m_reset();
    forever begin
      @(negedge clk);
      if (rst) m_reset();
      else if (cap_new) m_step(cap_hs, cap_vs, cap_hb, cap_vb);
      n_vec++;
      chk("x_pos", x_pos, m_x);
      chk("y_pos", y_pos, m_lines);
      chk("de", de, m_de);
      chk("locked", locked, m_mode == 2);
      chk("err", err, m_err);
      chk("err_cnt", err_cnt, CNT_EN ? m_cnt : 0);
      if (rst) chk("rst_outputs", {x_pos, y_pos, de, locked, err, err_cnt}, 0);
      if (!rst && cap_new && cap_org) begin
        chk("origin_x", x_pos, 0);
        chk("origin_y", y_pos, 0);
      end
      if (err) err_total++;
      if (de) de_total++;
      if (locked && !prev_locked) lock_rise_cyc = cyc;
      prev_locked = locked;
    end
  end

  task automatic drive(input logic hs, input logic vs, input logic hb, input logic vb,
                       input bit origin, input int px, input int ln);
    @(posedge clk);
    #1;
    vif.hsync = hs; vif.vsync = vs; vif.hblnk = hb; vif.vblnk = vb;
    vif.hcount = 11'(px); vif.vcount = 11'(ln);
    org = origin;
    if (origin) fs_cyc.push_back(cyc);
  endtask

  task automatic send_line(input int ln, input int len, input int hs_off, input int voff,
                           input int glitch, input int rst_px);
    int hold;
    hold = 0;
    for (int px = 0; px < len; px++) begin
      logic hs, vs;
      hs = (px >= HSS + hs_off) && (px < HSS + hs_off + HSW);
      vs = (ln >= VSS + voff) && (ln < VSS + VSW + voff);
      if (px == glitch) vs = !vs;
      drive(hs, vs, px >= HA, ln >= VA, (px == 0) && (ln == 0), px, ln);
      if (hold > 0) begin
        hold--;
        if (hold == 0) rst = 1'b0;
      end
      if (px == rst_px) begin rst = 1'b1; hold = 2; end
    end
  endtask

  task automatic send_frame(input int bad_ln, input int bad_len, input int bad_hs,
                            input int rst_ln, input int rst_px);
    for (int ln = 0; ln < VT; ln++)
      send_line(ln, (ln == bad_ln) ? bad_len : HT, (ln == bad_ln) ? bad_hs : 0, 0, -1,
                (ln == rst_ln) ? rst_px : -1);
  endtask

  task automatic clean_frames(input int n);
    for (int i = 0; i < n; i++) send_frame(-1, HT, 0, -1, -1);
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    rst = 1'b0;
    repeat (2) drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
  endtask

  int e0, d0;

  initial begin
    vif.hsync = 0; vif.vsync = 0; vif.hblnk = 1; vif.vblnk = 1;
    vif.hcount = 0; vif.vcount = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_locked", locked, 0);
    chk("reset_err_cnt", err_cnt, 0);
    chk("reset_x", x_pos, 0);
    rst = 1'b0;
    repeat (3) drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);

    // clean lock-up
    fs_cyc.delete();
    clean_frames(3);
    chk("lock_after_3rd_fs", lock_rise_cyc, (fs_cyc.size() >= 3) ? fs_cyc[2] + 1 : -2);
    chk("clean_no_err", err_total, 0);
    d0 = de_total;
    clean_frames(1);
    chk("de_per_frame", de_total - d0, HA * VA);

    // one short line while locked
    e0 = err_total;
    send_frame(3, HT - 1, 0, -1, -1);
    chk("short_line_pulses", err_total - e0, 1);
    chk("short_line_cnt", err_cnt, CNT_EN ? 1 : 0);
    chk("short_line_unlock", locked, 0);
    clean_frames(3);
    chk("short_line_relock", locked, 1);

    // hsync one pixel late on one line
    e0 = err_total;
    send_frame(2, HT, 1, -1, -1);
    chk("hs_shift_pulses", err_total - e0, 2);
    chk("hs_shift_cnt", err_cnt, CNT_EN ? 3 : 0);
    chk("hs_shift_unlock", locked, 0);
    clean_frames(3);
    chk("hs_shift_relock", locked, 1);

    // reset mid-frame, then relock with no spurious errors
    e0 = err_total;
    send_frame(-1, HT, 0, 4, 10);
    chk("mid_rst_cleared", err_cnt, 0);
    clean_frames(2);
    chk("mid_rst_not_yet", locked, 0);
    clean_frames(1);
    chk("mid_rst_relock", locked, 1);
    chk("mid_rst_no_err", err_total - e0, 0);

    // randomized corruption
    for (int f = 0; f < 12; f++) begin
      int voff;
      voff = ($urandom_range(0, 3) == 0) ? 1 : 0;
      for (int ln = 0; ln < VT; ln++) begin
        int len, hso, gl, rp;
        len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(HT - 3, HT + 3)) : HT;
        hso = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2)) - 1 : 0;
        gl  = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, HT - 4)) : -1;
        rp  = ($urandom_range(0, 60) == 0) ? int'($urandom_range(0, HT - 8)) : -1;
        send_line(ln, len, hso, voff, gl, rp);
      end
    end
    clean_frames(3);
    chk("random_relock", locked, 1);

    // blanking held long enough for x to saturate
    e0 = err_total;
    for (int i = 0; i < 2100; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, i, VT - 1);
    chk("x_sat_pulses", err_total - e0, 1);
    chk("x_sat_value", x_pos, 2047);
    clean_frames(1);

    // error counter saturation
    reset_pulse();
    for (int i = 0; i < 300; i++) send_line(i % VT, HT - 1, 0, 0, -1, -1);
    chk("err_cnt_sat", err_cnt, CNT_EN ? 255 : 0);
    clean_frames(1);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
